// File: rtl/sevenseg_pkg.sv
// Shared seven-segment types and the BCD-to-segment table.
// Segment bit order is {g,f,e,d,c,b,a}; all patterns are active-high.
package sevenseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b000_0000;

    // Codes above 9 are not BCD digits and show nothing.
    function automatic seg_t bcd_to_seg(input logic [3:0] bcd);
        seg_t pat;
        case (bcd)
            4'd0:    pat = 7'b011_1111;
            4'd1:    pat = 7'b000_0110;
            4'd2:    pat = 7'b101_1011;
            4'd3:    pat = 7'b100_1111;
            4'd4:    pat = 7'b110_0110;
            4'd5:    pat = 7'b110_1101;
            4'd6:    pat = 7'b111_1101;
            4'd7:    pat = 7'b000_0111;
            4'd8:    pat = 7'b111_1111;
            4'd9:    pat = 7'b110_1111;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/sevenseg_decoder.sv
// Combinational BCD to seven-segment decoder, providing both output polarities.
module sevenseg_decoder
    import sevenseg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] sevenseg,
    output logic [6:0] sevenseg_n
);

    assign sevenseg   = bcd_to_seg(bcd);
    assign sevenseg_n = ~bcd_to_seg(bcd);

endmodule

// File: rtl/sevenseg_mux_driver.sv
// Multiplexed N-digit seven-segment driver: shadow/active digit registers, scan prescaler,
// leading-zero blanking and registered outputs. Blinking is built only with SEVENSEG_BLINK_EN.
module sevenseg_mux_driver
    import sevenseg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 100
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic [6:0]            seg_n,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_start
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]          pcnt_q, pcnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   pcnt_tc, idx_tc, frame_tc;
    logic                   bnd_q;

    logic [4*DIGITS-1:0]    sh_bcd_q, act_bcd_q;
    logic [DIGITS-1:0]      sh_dp_q, act_dp_q;
    logic [DIGITS-1:0]      sh_blink_q, act_blink_q;

    logic [3:0]             sel_bcd;
    logic                   sel_dp, sel_blink, sel_lz;
    logic [DIGITS-1:0]      lz;
    logic                   zero_run;
    logic                   phase;
    logic                   lz_blank, bl_blank;

    logic [6:0]             dec_seg, dec_seg_n;
    logic [6:0]             seg_d, seg_n_d, seg_q, seg_n_q;
    logic                   dp_d, dp_q;
    logic [DIGITS-1:0]      an_d, an_q, an_n_q;
    logic                   fs_q;

    always_comb begin
        pcnt_tc  = (pcnt_q == PW'(SCAN_DIV - 1));
        idx_tc   = (idx_q == IW'(DIGITS - 1));
        frame_tc = pcnt_tc && idx_tc;
        pcnt_d   = pcnt_tc ? '0 : pcnt_q + 1'b1;
        idx_d    = idx_q;
        if (pcnt_tc) begin
            idx_d = idx_tc ? '0 : idx_q + 1'b1;
        end
    end

    // lz[i] is set when active digits DIGITS-1..i are all zero; digit 0 is never included.
    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (act_bcd_q[4*i +: 4] == 4'd0);
            lz[i]    = zero_run;
        end
    end

    always_comb begin
        sel_bcd   = '0;
        sel_dp    = 1'b0;
        sel_blink = 1'b0;
        sel_lz    = 1'b0;
        an_d      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            an_d[i] = (idx_q == IW'(i));
            if (idx_q == IW'(i)) begin
                sel_bcd   = act_bcd_q[4*i +: 4];
                sel_dp    = act_dp_q[i];
                sel_blink = act_blink_q[i];
                sel_lz    = lz[i];
            end
        end
    end

`ifdef SEVENSEG_BLINK_EN
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (frame_tc) begin
            if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
`else
    assign phase = 1'b0;
`endif

    sevenseg_decoder u_dec (
        .bcd        (sel_bcd),
        .sevenseg   (dec_seg),
        .sevenseg_n (dec_seg_n)
    );

    always_comb begin
        lz_blank = blank_lz && sel_lz;
        bl_blank = phase && sel_blink;
        seg_d    = (lz_blank || bl_blank) ? SEG_BLANK  : dec_seg;
        seg_n_d  = (lz_blank || bl_blank) ? ~SEG_BLANK : dec_seg_n;
        dp_d     = sel_dp && !bl_blank;
    end

    // The frame-boundary flag is delayed once so frame_start lines up with digit 0 on the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q      <= '0;
            idx_q       <= '0;
            bnd_q       <= 1'b0;
            sh_bcd_q    <= '0;
            sh_dp_q     <= '0;
            sh_blink_q  <= '0;
            act_bcd_q   <= '0;
            act_dp_q    <= '0;
            act_blink_q <= '0;
            seg_q       <= SEG_BLANK;
            seg_n_q     <= ~SEG_BLANK;
            dp_q        <= 1'b0;
            an_q        <= '0;
            an_n_q      <= '1;
            fs_q        <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            idx_q  <= idx_d;
            bnd_q  <= frame_tc;
            if (load) begin
                sh_bcd_q   <= bcd_in;
                sh_dp_q    <= dp_in;
                sh_blink_q <= blink_mask;
            end
            if (frame_tc) begin
                act_bcd_q   <= sh_bcd_q;
                act_dp_q    <= sh_dp_q;
                act_blink_q <= sh_blink_q;
            end
            seg_q   <= seg_d;
            seg_n_q <= seg_n_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            an_n_q  <= ~an_d;
            fs_q    <= bnd_q;
        end
    end

    assign seg         = seg_q;
    assign seg_n       = seg_n_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign an_n        = an_n_q;
    assign frame_start = fs_q;

endmodule
